// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - RV32I load/store funct3 encodings
//   - FSM state encoding of the request/response sequencer
//   - request legality check and load-lane extension helpers
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Flags a request that must not touch memory: unknown funct3, unsigned
    // variants used as stores, or a halfword/word access off its natural
    // boundary.
    function automatic logic lsu_req_err(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] lane);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = |lane;
            F3_BU:   err = we;
            F3_HU:   err = we | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Picks the addressed byte/halfword out of a little-endian word and
    // sign- or zero-extends it to 32 bits.
    function automatic logic [31:0] lsu_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h000000, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0000, h};
            F3_W:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// DEPTH_WORDS x 32-bit data RAM with per-byte write enables.
// Read and write share one port and one edge; the read returns the word as it
// was before that edge's write. Contents are never cleared by reset.
//
// Ports:
//   clk    in   clock
//   en     in   access strobe; rdata updates only when set
//   be     in   byte enables for the write (bit i -> bits 8i+7:8i)
//   addr   in   word index
//   wdata  in   write data, already steered onto byte lanes
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module dmem_bank #(
    parameter int    DEPTH_WORDS = 64,
    parameter string INIT_FILE   = "",
    localparam int   AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// RV32I load/store unit with an integrated byte-addressable data memory and a
// configurable access latency exposed through a valid/ready handshake.
// One request is outstanding at a time. Stores commit on the acceptance edge;
// loads read the whole word on the acceptance edge and extract/extend the
// addressed lane while the response is presented.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  unit can accept a request this cycle
//   req_we      in   1 = store, 0 = load
//   req_funct3  in   RV32I funct3 (b, h, w, bu, hu)
//   req_addr    in   byte address (wraps modulo 4*DEPTH_WORDS)
//   req_wdata   in   store data, LSB-aligned
//   rsp_valid   out  one-cycle response pulse
//   rsp_rdata   out  extended load data; 0 for stores and errors
//   rsp_err     out  misaligned or illegal request
//   busy        out  request outstanding (pipeline stall source)
// -----------------------------------------------------------------------------
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int    DEPTH_WORDS = 64,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // WAIT lasts LATENCY-1 cycles; the counter is loaded with one less than
    // that and RESP follows when it reaches zero.
    localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;

    logic        accept;
    logic [1:0]  lane;
    logic        req_err;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_word;

    logic [1:0]  cap_lane;
    logic [2:0]  cap_funct3;
    logic        cap_load;
    logic        cap_err;

    logic [31:0] resp_rdata;
    logic [31:0] hold_rdata;
    logic        hold_err;

    // Address bits above the word index are ignored so addresses alias.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign busy      = (state != IDLE) | accept;
    assign lane      = req_addr[1:0];
    assign req_err   = lsu_req_err(req_we, req_funct3, lane);

    // Store lane steering: the source byte/halfword is replicated across the
    // word so only the enables depend on the address.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        if (accept && req_we && !req_err) begin
            case (req_funct3)
                F3_B: begin
                    wr_be   = 4'b0001 << lane;
                    wr_data = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{req_wdata[15:0]}};
                end
                F3_W: begin
                    wr_be   = 4'b1111;
                end
                default: begin
                    wr_be   = 4'b0000;
                end
            endcase
        end
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_bank (
        .clk  (clk),
        .en   (accept),
        .be   (wr_be),
        .addr (req_addr[AW+1:2]),
        .wdata(wr_data),
        .rdata(rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request attributes captured alongside the memory word; only meaningful
    // while a response is pending, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_lane   <= lane;
            cap_funct3 <= req_funct3;
            cap_load   <= !req_we && !req_err;
            cap_err    <= req_err;
        end
    end

    assign resp_rdata = cap_load ? lsu_extend(rd_word, cap_lane, cap_funct3) : 32'h0000_0000;

    // The response is formed in RESP and latched so it stays visible until
    // the next response replaces it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_rdata <= 32'h0000_0000;
            hold_err   <= 1'b0;
        end else if (state == RESP) begin
            hold_rdata <= resp_rdata;
            hold_err   <= cap_err;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? resp_rdata : hold_rdata;
    assign rsp_err   = rsp_valid ? cap_err    : hold_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Two instances of dmem_lsu (LATENCY 1 and 3) driven by directed and random
// request streams. Each instance has its own memory model and response queue;
// a per-instance monitor pops expectations when rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference rules for requests, written from the ISA-level description.
    function automatic bit is_err(input bit we, input int f3, input int a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (we && (f3 == 4 || f3 == 5))    return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
        if (f3 == 2 && a != 0)             return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input int f3, input int a);
        logic [31:0] s;
        s = w >> (8 * a);
        case (f3)
            0: return (s[7]  ? 32'hFFFF_FF00 : 32'h0) | (s & 32'h0000_00FF);
            4: return s & 32'h0000_00FF;
            1: return (s[15] ? 32'hFFFF_0000 : 32'h0) | (s & 32'h0000_FFFF);
            5: return s & 32'h0000_FFFF;
            2: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] old, input logic [31:0] wd,
                                              input int f3, input int a);
        logic [31:0] m;
        case (f3)
            0:       m = 32'h0000_00FF << (8 * a);
            1:       m = 32'h0000_FFFF << (8 * a);
            2:       m = 32'hFFFF_FFFF;
            default: m = 32'h0;
        endcase
        return (old & ~m) | ((wd << (8 * a)) & m);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        reset;
        logic        req_valid;
        logic        req_ready;
        logic        req_we;
        logic [2:0]  req_funct3;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        logic        busy;

        logic [31:0] model [DEPTH];
        exp_t        q[$];
        exp_t        e;
        logic [31:0] last_rdata;
        logic        last_err;
        bit          done = 1'b0;

        dmem_lsu #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    (LAT),
            .INIT_FILE  ("")
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_we    (req_we),
            .req_funct3(req_funct3),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err),
            .busy      (busy)
        );

        task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
            chk($sformatf("L%0d %s", LAT, nm), act, exp);
        endtask

        // Presents a request (called at a negedge), waits for acceptance,
        // records the expected response, then waits until ready returns.
        // req_valid stays high so a following issue() exercises back-to-back.
        task automatic issue(input bit we, input int f3, input logic [31:0] addr,
                             input logic [31:0] wd);
            int n;
            int idx;
            int a;
            int acc;
            exp_t x;
            req_we     = we;
            req_funct3 = 3'(f3);
            req_addr   = addr;
            req_wdata  = wd;
            req_valid  = 1'b1;
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready) begin
                checks++;
                $display("FAIL L%0d accept timeout: req_ready stayed 0 for %0d cycles", LAT, n);
                return;
            end
            idx = int'((addr >> 2) % DEPTH);
            a   = int'(addr % 4);
            acc = cyc + 1;
            x.err   = is_err(we, f3, a);
            x.acc   = acc;
            x.rdata = (we || x.err) ? 32'h0 : load_val(model[idx], f3, a);
            if (we && !x.err) model[idx] = store_val(model[idx], wd, f3, a);
            q.push_back(x);
            @(posedge clk);
            @(negedge clk);
            ck("ready low after accept", {31'b0, req_ready}, 32'd0);
            n = 0;
            while (!req_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            ck("ready return cycle", cyc, acc + LAT);
        endtask

        task automatic idle(input int n);
            req_valid = 1'b0;
            repeat (n) @(negedge clk);
        endtask

        always @(negedge clk) begin
            if (reset) begin
                last_rdata = 32'h0;
                last_err   = 1'b0;
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL L%0d unexpected rsp_valid: rdata %h err %0b, no request pending",
                             LAT, rsp_rdata, rsp_err);
                end else begin
                    e = q.pop_front();
                    ck("rsp_rdata", rsp_rdata, e.rdata);
                    ck("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    ck("rsp cycle", cyc, e.acc + LAT - 1);
                    last_rdata = e.rdata;
                    last_err   = e.err;
                end
            end else begin
                ck("held rdata", rsp_rdata, last_rdata);
                ck("held err", {31'b0, rsp_err}, {31'b0, last_err});
                ck("busy", {31'b0, busy}, {31'b0, !req_ready || (req_valid && req_ready)});
            end
        end

        initial begin
            logic [31:0] ra;
            reset      = 1'b1;
            req_valid  = 1'b0;
            req_we     = 1'b0;
            req_funct3 = 3'd0;
            req_addr   = 32'h0;
            req_wdata  = 32'h0;
            repeat (3) @(negedge clk);
            ck("reset req_ready", {31'b0, req_ready}, 32'd1);
            ck("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
            ck("reset rsp_rdata", rsp_rdata, 32'h0);
            ck("reset rsp_err", {31'b0, rsp_err}, 32'd0);
            ck("reset busy", {31'b0, busy}, 32'd0);
            reset = 1'b0;
            @(negedge clk);

            for (int i = 0; i < DEPTH; i++) issue(1'b1, 2, 32'(i * 4), $urandom);

            issue(1'b1, 2, 32'h10, 32'hDEAD_BEEF);
            issue(1'b0, 2, 32'h10, 32'h0);
            issue(1'b1, 0, 32'h21, 32'h0000_0080);
            issue(1'b0, 0, 32'h21, 32'h0);
            issue(1'b0, 4, 32'h21, 32'h0);
            issue(1'b0, 2, 32'h20, 32'h0);
            issue(1'b1, 1, 32'h32, 32'h0000_8001);
            issue(1'b0, 1, 32'h32, 32'h0);
            issue(1'b0, 5, 32'h32, 32'h0);
            issue(1'b0, 1, 32'h33, 32'h0);
            issue(1'b0, 2, 32'h30, 32'h0);
            issue(1'b1, 2, 32'h100, 32'h1234_5678);
            issue(1'b0, 2, 32'h0, 32'h0);
            issue(1'b1, 2, 32'h42, 32'hCAFE_F00D);
            issue(1'b1, 4, 32'h44, 32'h0000_0055);
            issue(1'b1, 1, 32'h47, 32'h0000_1234);
            issue(1'b1, 7, 32'h40, 32'hFFFF_FFFF);
            issue(1'b0, 3, 32'h44, 32'h0);
            issue(1'b0, 6, 32'h44, 32'h0);
            issue(1'b0, 2, 32'h40, 32'h0);
            issue(1'b0, 2, 32'h44, 32'h0);
            idle(2);

            // Reset while a load is in flight.
            issue(1'b1, 2, 32'h50, 32'hA5A5_5A5A);
            issue(1'b0, 2, 32'h50, 32'h0);
            req_we     = 1'b0;
            req_funct3 = 3'd2;
            req_addr   = 32'h54;
            req_valid  = 1'b1;
            @(posedge clk);
            #2;
            reset     = 1'b1;
            req_valid = 1'b0;
            #1;
            ck("mid reset req_ready", {31'b0, req_ready}, 32'd1);
            ck("mid reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
            ck("mid reset rsp_rdata", rsp_rdata, 32'h0);
            ck("mid reset rsp_err", {31'b0, rsp_err}, 32'd0);
            ck("mid reset busy idle", {31'b0, busy}, 32'd0);
            req_valid = 1'b1;
            #1;
            ck("mid reset busy follows valid", {31'b0, busy}, 32'd1);
            req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            idle(LAT + 3);
            issue(1'b0, 2, 32'h50, 32'h0);

            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                ra = $urandom;
                if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
                issue(1'($urandom_range(0, 1)), $urandom_range(0, 7), ra, $urandom);
            end
            for (int i = 0; i < DEPTH; i++) issue(1'b0, 2, 32'(i * 4), 32'h0);
            idle(LAT + 3);
            ck("queue drained", 32'(q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_inst[0].done && g_inst[1].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_inst[0].done && g_inst[1].done)) begin
            checks++;
            $display("FAIL run timeout: stimulus incomplete after %0d cycles", n);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
